// File: rtl/mem_access_unit.sv
// Initiator side of the byte-addressed, big-endian 32-bit data memory port.
// Serves load/store/swap requests, doing read-modify-write for sub-word stores.
module mem_access_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dat_in,
   output logic        mem_we,
   output logic        mem_swap,
   input  logic [31:0] mem_dat_out
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_SWAP  = 2'b10;
   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [1:0]        offset_q, offset_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [31:0]       rsp_rdata_d;
   logic              rsp_err_d;
   logic [31:0]       mem_addr_d;
   logic [31:0]       mem_dat_in_d;
   logic              mem_we_d;

   logic              req_err;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign mem_swap  = 1'b0;

   // Reserved encodings, sub-word swaps and misaligned accesses never touch memory.
   always_comb begin
      req_err = 1'b0;
      if (req_op == 2'b11 || req_size == 2'b11)
         req_err = 1'b1;
      if (req_op == OP_SWAP && req_size != SZ_WORD)
         req_err = 1'b1;
      if (req_size == SZ_HALF && req_addr[0])
         req_err = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
   end

   // Big-endian lane select: offset 0 is the most significant byte.
   always_comb begin
      case (offset_q)
         2'd0:    lane_byte = mem_dat_out[31:24];
         2'd1:    lane_byte = mem_dat_out[23:16];
         2'd2:    lane_byte = mem_dat_out[15:8];
         default: lane_byte = mem_dat_out[7:0];
      endcase
      lane_half = offset_q[1] ? mem_dat_out[15:0] : mem_dat_out[31:16];
      case (size_q)
         SZ_BYTE: load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
         SZ_HALF: load_data = {{16{signed_q & lane_half[15]}}, lane_half};
         default: load_data = mem_dat_out;
      endcase
   end

   always_comb begin
      merge_data = mem_dat_out;
      if (size_q == SZ_BYTE) begin
         case (offset_q)
            2'd0:    merge_data[31:24] = wdata_q[7:0];
            2'd1:    merge_data[23:16] = wdata_q[7:0];
            2'd2:    merge_data[15:8]  = wdata_q[7:0];
            default: merge_data[7:0]   = wdata_q[7:0];
         endcase
      end else if (offset_q[1]) begin
         merge_data[15:0] = wdata_q[15:0];
      end else begin
         merge_data[31:16] = wdata_q[15:0];
      end
   end

   // Next-state logic; every memory-facing output is registered so it cannot glitch.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      size_d       = size_q;
      signed_d     = signed_q;
      offset_d     = offset_q;
      wdata_d      = wdata_q;
      lat_d        = lat_q;
      rsp_rdata_d  = rsp_rdata;
      rsp_err_d    = rsp_err;
      mem_addr_d   = mem_addr;
      mem_dat_in_d = mem_dat_in;
      mem_we_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d        = req_op;
               size_d      = req_size;
               signed_d    = req_signed;
               offset_d    = req_addr[1:0];
               wdata_d     = req_wdata;
               lat_d       = '0;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               if (req_err) begin
                  rsp_err_d = 1'b1;
                  state_d   = RESP;
               end else if (req_op == OP_STORE && req_size == SZ_WORD) begin
                  mem_addr_d   = {req_addr[31:2], 2'b00};
                  mem_dat_in_d = req_wdata;
                  mem_we_d     = 1'b1;
                  state_d      = WRITE;
               end else begin
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  state_d    = READ;
               end
            end
         end
         READ: begin
            if (lat_q == LAT_LAST) begin
               if (op_q == OP_LOAD) begin
                  rsp_rdata_d = load_data;
                  state_d     = RESP;
               end else if (op_q == OP_SWAP) begin
                  rsp_rdata_d  = mem_dat_out;
                  mem_dat_in_d = wdata_q;
                  mem_we_d     = 1'b1;
                  state_d      = WRITE;
               end else begin
                  mem_dat_in_d = merge_data;
                  mem_we_d     = 1'b1;
                  state_d      = WRITE;
               end
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         WRITE: begin
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= 2'b00;
         size_q     <= 2'b00;
         signed_q   <= 1'b0;
         offset_q   <= 2'b00;
         wdata_q    <= 32'h0;
         lat_q      <= '0;
         rsp_rdata  <= 32'h0;
         rsp_err    <= 1'b0;
         mem_addr   <= 32'h0;
         mem_dat_in <= 32'h0;
         mem_we     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         offset_q   <= offset_d;
         wdata_q    <= wdata_d;
         lat_q      <= lat_d;
         rsp_rdata  <= rsp_rdata_d;
         rsp_err    <= rsp_err_d;
         mem_addr   <= mem_addr_d;
         mem_dat_in <= mem_dat_in_d;
         mem_we     <= mem_we_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table scored through a response queue,
// plus back-pressure and reset-during-write sequences.
module tb_mem_access_unit;

   localparam int MEM_LAT = 1;
   localparam logic [1:0] OP_LD = 2'b00, OP_ST = 2'b01, OP_SW = 2'b10, OP_RS = 2'b11;
   localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          we;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          we_total;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_dat_in;
   logic        mem_we;
   logic        mem_swap;
   logic [31:0] mem_dat_out;

   int   checks = 0;
   int   failures = 0;
   int   cur = -1;
   int   we_count = 0;
   exp_t sb[$];
   vec_t vecs[27];

   logic [7:0] mem [0:1023];
   logic [9:0] ma;

   mem_access_unit #(.MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
      .mem_dat_in(mem_dat_in), .mem_we(mem_we), .mem_swap(mem_swap),
      .mem_dat_out(mem_dat_out)
   );

   always #5 clk = ~clk;

   // Level-sensitive big-endian memory: combinational read, write on edges with mem_we high.
   assign ma = mem_addr[9:0];
   assign mem_dat_out = {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};

   always @(posedge clk) begin
      if (mem_we) begin
         mem[ma]         <= mem_dat_in[31:24];
         mem[ma + 10'd1] <= mem_dat_in[23:16];
         mem[ma + 10'd2] <= mem_dat_in[15:8];
         mem[ma + 10'd3] <= mem_dat_in[7:0];
         we_count        <= we_count + 1;
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s (vec %0d) actual=0x%08h expected=0x%08h", name, cur, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(negedge clk);
      check32("ready_idle", {31'b0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_op     = v.op;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      e.rdata    = v.rdata;
      e.err      = v.err;
      e.lat      = v.lat;
      e.we_total = we_count + v.we;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic checkOutput(input int hold);
      exp_t e;
      int   lat;
      bit   seen;
      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (rsp_valid) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL rsp_timeout (vec %0d) actual=no_rsp expected=rsp_valid", cur);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      check32("rdata", rsp_rdata, e.rdata);
      check32("err", {31'b0, rsp_err}, {31'b0, e.err});
      check32("latency", lat, e.lat);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check32("hold_valid", {31'b0, rsp_valid}, 32'h1);
         check32("hold_rdata", rsp_rdata, e.rdata);
         check32("hold_ready", {31'b0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check32("rsp_drop", {31'b0, rsp_valid}, 32'h0);
      check32("we_pulses", we_count, e.we_total);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      vecs[0]  = '{OP_ST, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
      vecs[1]  = '{OP_LD, SZ_W, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
      vecs[2]  = '{OP_ST, SZ_W, 1'b0, 32'h100, 32'h11223344, 32'h0,        1'b0, 2, 1};
      vecs[3]  = '{OP_ST, SZ_B, 1'b0, 32'h101, 32'h000001AB, 32'h0,        1'b0, 3, 1};
      vecs[4]  = '{OP_LD, SZ_W, 1'b0, 32'h100, 32'h0,        32'h11AB3344, 1'b0, 2, 0};
      vecs[5]  = '{OP_LD, SZ_B, 1'b1, 32'h101, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0};
      vecs[6]  = '{OP_LD, SZ_B, 1'b0, 32'h101, 32'h0,        32'h000000AB, 1'b0, 2, 0};
      vecs[7]  = '{OP_ST, SZ_H, 1'b0, 32'h102, 32'h55558344, 32'h0,        1'b0, 3, 1};
      vecs[8]  = '{OP_LD, SZ_W, 1'b0, 32'h100, 32'h0,        32'h11AB8344, 1'b0, 2, 0};
      vecs[9]  = '{OP_LD, SZ_H, 1'b1, 32'h102, 32'h0,        32'hFFFF8344, 1'b0, 2, 0};
      vecs[10] = '{OP_LD, SZ_H, 1'b0, 32'h100, 32'h0,        32'h000011AB, 1'b0, 2, 0};
      vecs[11] = '{OP_LD, SZ_H, 1'b0, 32'h103, 32'h0,        32'h0,        1'b1, 1, 0};
      vecs[12] = '{OP_ST, SZ_W, 1'b0, 32'h102, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
      vecs[13] = '{OP_RS, SZ_W, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
      vecs[14] = '{OP_SW, SZ_B, 1'b0, 32'h200, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0};
      vecs[15] = '{OP_ST, SZ_W, 1'b0, 32'h200, 32'h12345678, 32'h0,        1'b0, 2, 1};
      vecs[16] = '{OP_SW, SZ_W, 1'b0, 32'h200, 32'hCAFEF00D, 32'h12345678, 1'b0, 3, 1};
      vecs[17] = '{OP_LD, SZ_W, 1'b0, 32'h200, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0};
      vecs[18] = '{OP_LD, SZ_W, 1'b1, 32'h200, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0};
      vecs[19] = '{OP_LD, SZ_B, 1'b0, 32'h203, 32'h0,        32'h0000000D, 1'b0, 2, 0};
      vecs[20] = '{OP_LD, SZ_B, 1'b1, 32'h200, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 0};
      vecs[21] = '{OP_LD, SZ_R, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1, 1, 0};
      vecs[22] = '{OP_ST, SZ_B, 1'b0, 32'h102, 32'hFFFFFF00, 32'h0,        1'b0, 3, 1};
      vecs[23] = '{OP_LD, SZ_W, 1'b0, 32'h100, 32'h0,        32'h11AB0044, 1'b0, 2, 0};
      vecs[24] = '{OP_LD, SZ_H, 1'b1, 32'h100, 32'h0,        32'h000011AB, 1'b0, 2, 0};
      vecs[25] = '{OP_LD, SZ_B, 1'b1, 32'h102, 32'h0,        32'h00000000, 1'b0, 2, 0};
      vecs[26] = '{OP_LD, SZ_H, 1'b0, 32'h202, 32'h0,        32'h0000F00D, 1'b0, 2, 0};

      #2 rst_n = 1'b0;
      @(negedge clk);
      check32("rst_req_ready", {31'b0, req_ready}, 32'h1);
      check32("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check32("rst_rsp_rdata", rsp_rdata, 32'h0);
      check32("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      check32("rst_mem_addr", mem_addr, 32'h0);
      check32("rst_mem_dat_in", mem_dat_in, 32'h0);
      check32("rst_mem_we", {31'b0, mem_we}, 32'h0);
      check32("rst_mem_swap", {31'b0, mem_swap}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         cur = i;
         applyStimulus(vecs[i]);
         checkOutput(0);
         if (i == 0) begin
            check32("mem_100", {24'b0, mem[10'h100]}, 32'hDE);
            check32("mem_101", {24'b0, mem[10'h101]}, 32'hAD);
            check32("mem_102", {24'b0, mem[10'h102]}, 32'hBE);
            check32("mem_103", {24'b0, mem[10'h103]}, 32'hEF);
         end
      end
      check32("mem_200_word", {mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]}, 32'hCAFEF00D);

      // Back-pressure: response must hold steady while rsp_ready stays low.
      cur = 100;
      v = '{OP_LD, SZ_W, 1'b0, 32'h100, 32'h0, 32'h11AB0044, 1'b0, 2, 0};
      applyStimulus(v);
      checkOutput(5);

      // Reset while the write pulse is high: write dropped, no response produced.
      cur = 101;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_ST;
      req_size  = SZ_W;
      req_addr  = 32'h100;
      req_wdata = 32'h0BADF00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check32("we_in_write", {31'b0, mem_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      check32("we_async_drop", {31'b0, mem_we}, 32'h0);
      check32("rst_ready_mid", {31'b0, req_ready}, 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check32("no_rsp_after_rst", {31'b0, rsp_valid}, 32'h0);
      end
      check32("mem_after_rst", {mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]}, 32'h11AB0044);

      cur = 102;
      v = '{OP_LD, SZ_W, 1'b0, 32'h100, 32'h0, 32'h11AB0044, 1'b0, 2, 0};
      applyStimulus(v);
      checkOutput(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
